// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register/port constants and a clog2 helper
package cpu_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ZERO = 0;
  localparam int WB_PORT = 0;
  localparam int ATOMIC_PORT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/regfile_pend_ctr.sv
// regfile_pend_ctr: saturating pending-write counter for one register (REGFILE_BYPASS_EN adds a last output)
module regfile_pend_ctr #(
  parameter int MAX_PEND = 3,
  parameter int PW = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic inc,
  input  logic dec,
  output logic busy,
`ifdef REGFILE_BYPASS_EN
  output logic last,
`endif
  output logic full
);
  logic [PW-1:0] cnt_q, cnt_d;
  assign busy = cnt_q != '0;
  assign full = cnt_q == PW'(MAX_PEND);
`ifdef REGFILE_BYPASS_EN
  assign last = cnt_q == PW'(1);
`endif
  // a matched inc/dec cancels; a decrement with nothing pending stays at zero
  always_comb
    cnt_d = flush ? '0 : (inc && !dec) ? cnt_q + 1'b1 : (dec && !inc && busy) ? cnt_q - 1'b1 : cnt_q;
  // counter state, cleared by reset
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-register pending-write scoreboard (REGFILE_BYPASS_EN enables write forwarding)
module regfile_mp import cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int MAX_PEND = 3,
  localparam int AW = clog2(NREGS),
  localparam int PW = clog2(MAX_PEND + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_rd,
  output logic                   alloc_ready,
  input  logic                   flush
);
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [NREGS-1:0] valid_q, valid_d;
  logic [NREGS-1:1] dec;
  logic [NREGS-1:0] busy, full;
  logic alloc_ok;
  assign busy[0] = 1'b0;
  assign full[0] = 1'b0;
  assign alloc_ready = alloc_rd == AW'(REG_ZERO) || !full[alloc_rd];
  assign alloc_ok = alloc_en && alloc_ready && !flush;
`ifdef REGFILE_BYPASS_EN
  logic [NREGS-1:0] last;
  assign last[0] = 1'b0;
`endif
  // commit writes in port order so the highest-index port wins; reset only clears valid bits
  always_comb begin
    mem_d = mem_q;
    valid_d = valid_q;
    dec = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] != AW'(REG_ZERO)) begin
        mem_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
        valid_d[wr_addr[p*AW +: AW]] = 1'b1;
        dec[wr_addr[p*AW +: AW]] = 1'b1;
      end
    if (reset) valid_d = '0;
  end
  // storage and valid bits
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    valid_q <= valid_d;
  end
  for (genvar r = 1; r < NREGS; r++) begin : g_ctr
    regfile_pend_ctr #(.MAX_PEND(MAX_PEND), .PW(PW)) u_ctr (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .inc(alloc_ok && alloc_rd == AW'(r)),
      .dec(dec[r]),
      .busy(busy[r]),
`ifdef REGFILE_BYPASS_EN
      .last(last[r]),
`endif
      .full(full[r])
    );
  end
  // combinational read ports; unwritten registers and x0 read as zero
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
      logic fwd;
`endif
      ra = rs_addr[i*AW +: AW];
      rs_data[i*XLEN +: XLEN] = (ra != AW'(REG_ZERO) && valid_q[ra]) ? mem_q[ra] : '0;
      rs_busy[i] = busy[ra];
`ifdef REGFILE_BYPASS_EN
      fwd = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] && ra != AW'(REG_ZERO) && wr_addr[p*AW +: AW] == ra) begin
          rs_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
          fwd = 1'b1;
        end
      if (fwd && last[ra] && !(alloc_en && alloc_ready && alloc_rd == ra)) rs_busy[i] = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven directed check of regfile_mp reads, writes, scoreboard, flush and reset
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [9:0] rs_addr;
  logic [63:0] rs_data;
  logic [1:0] rs_busy;
  logic [1:0] wr_en;
  logic [9:0] wr_addr;
  logic [63:0] wr_data;
  logic alloc_en;
  logic [4:0] alloc_rd;
  logic alloc_ready;
  logic flush;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .flush(flush)
  );
  typedef struct {
    logic rst;
    logic [1:0] we;
    logic [4:0] wa0;
    logic [31:0] wd0;
    logic [4:0] wa1;
    logic [31:0] wd1;
    logic ae;
    logic [4:0] ard;
    logic fl;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0] eb;
    logic er;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic rst, input logic [1:0] we, input logic [4:0] wa0,
      input logic [31:0] wd0, input logic [4:0] wa1, input logic [31:0] wd1, input logic ae,
      input logic [4:0] ard, input logic fl, input logic [4:0] ra0, input logic [4:0] ra1,
      input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb, input logic er);
    vec_t t;
    t.rst = rst; t.we = we; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
    t.ae = ae; t.ard = ard; t.fl = fl; t.ra0 = ra0; t.ra1 = ra1;
    t.e0 = e0; t.e1 = e1; t.eb = eb; t.er = er;
    return t;
  endfunction
  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
    end
  endtask
  task automatic apply(input int n, input vec_t t);
    reset = t.rst; wr_en = t.we; wr_addr = {t.wa1, t.wa0}; wr_data = {t.wd1, t.wd0};
    alloc_en = t.ae; alloc_rd = t.ard; flush = t.fl; rs_addr = {t.ra1, t.ra0};
    #4;
    chk("rs_data0", n, rs_data[31:0], t.e0);
    chk("rs_data1", n, rs_data[63:32], t.e1);
    chk("rs_busy", n, {30'd0, rs_busy}, {30'd0, t.eb});
    chk("alloc_ready", n, {31'd0, alloc_ready}, {31'd0, t.er});
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_rd = '0; flush = 1'b0; rs_addr = '0;
    @(posedge clk);
    #1;
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 6, 0, 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 2'b00, 1));
    tv.push_back(mk(0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 8, 0, 0, 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 5, 32'h22, 32'hDEADBEEF, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0, 2'b11, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0, 2'b11, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0, 2'b11, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 9, 0, 9, 9, 0, 0, 2'b11, 0));
    tv.push_back(mk(0, 2'b01, 9, 32'hA1, 0, 0, 0, 9, 0, 9, 9, BYP ? 32'hA1 : 0, BYP ? 32'hA1 : 0, 2'b11, 0));
    tv.push_back(mk(0, 2'b10, 0, 0, 9, 32'hA2, 0, 9, 0, 9, 9, BYP ? 32'hA2 : 32'hA1, BYP ? 32'hA2 : 32'hA1, 2'b11, 1));
    tv.push_back(mk(0, 2'b11, 9, 32'hA3, 9, 32'hA4, 0, 9, 0, 9, 9, BYP ? 32'hA4 : 32'hA2, BYP ? 32'hA4 : 32'hA2, BYP ? 2'b00 : 2'b11, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 9, 0, 9, 9, 32'hA4, 32'hA4, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 32'hA4, 32'hA4, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 32'hA4, 32'hA4, 2'b11, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 1, 9, 9, 32'hA4, 32'hA4, 2'b11, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 9, 0, 9, 9, 32'hA4, 32'hA4, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 4, 0, 4, 4, 0, 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b01, 4, 32'h44, 0, 0, 1, 4, 0, 4, 4, BYP ? 32'h44 : 0, BYP ? 32'h44 : 0, 2'b11, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 4, 0, 4, 4, 32'h44, 32'h44, 2'b11, 1));
    tv.push_back(mk(0, 2'b10, 0, 0, 4, 32'h55, 0, 4, 0, 4, 4, BYP ? 32'h55 : 32'h44, BYP ? 32'h55 : 32'h44, BYP ? 2'b00 : 2'b11, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 4, 0, 4, 4, 32'h55, 32'h55, 2'b00, 1));
    tv.push_back(mk(0, 2'b01, 3, 32'hCAFE, 0, 0, 0, 0, 1, 3, 3, BYP ? 32'hCAFE : 0, BYP ? 32'hCAFE : 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 3, 32'hCAFE, 32'hCAFE, 2'b00, 1));
    tv.push_back(mk(1, 2'b01, 6, 32'h66, 0, 0, 1, 6, 0, 5, 6, 32'hDEADBEEF, BYP ? 32'h66 : 0, 2'b00, 1));
    tv.push_back(mk(0, 2'b00, 0, 0, 0, 0, 0, 6, 0, 5, 6, 0, 0, 2'b00, 1));
    for (int i = 0; i < tv.size(); i++) apply(i, tv[i]);
    apply(100, mk(0, 2'b00, 0, 0, 0, 0, 1, 10, 0, 10, 10, 0, 0, 2'b00, 1));
    apply(101, mk(0, 2'b01, 10, 32'hCAFE, 0, 0, 0, 10, 0, 10, 10, BYP ? 32'hCAFE : 0, BYP ? 32'hCAFE : 0, BYP ? 2'b00 : 2'b11, 1));
    apply(102, mk(0, 2'b00, 0, 0, 0, 0, 0, 10, 0, 10, 10, 32'hCAFE, 32'hCAFE, 2'b00, 1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
